blast_propagator: RTL and testbench
===================================

BLAST_PROPAGATOR -- requirements
Module: blast_propagator

Interface
REQ-001 Parameter NUM_ROW, 11: map rows.
REQ-002 Parameter NUM_COL, 19: map columns.
REQ-003 Parameter MAP_MEM_WIDTH, 2: tile code width; codes are 0 empty, 1 hard wall, 2 breakable, 3 bomb.
REQ-004 Parameter BLAST_RANGE, 2: maximum tiles reached per direction.
REQ-005 Parameter BLAST_TICKS, 30: tick pulses the blast stays active.
REQ-006 Parameter ADDR_WIDTH, clog2(NUM_ROW*NUM_COL), derived: width of a tile address.
REQ-007 clk  in  1  sole clock.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 tick  in  1  one-cycle frame pulse (60 Hz).
REQ-010 trigger_explosion  in  1  one-cycle pulse from the bomb stage.
REQ-011 bomb_addr  in  ADDR_WIDTH  bomb tile address (row*NUM_COL+col), valid with trigger.
REQ-012 rd_addr  out  ADDR_WIDTH  map read address.
REQ-013 rd_data  in  MAP_MEM_WIDTH  map read data; registered one cycle after rd_addr.
REQ-014 wr_addr / wr_data / wr_en  out  ADDR_WIDTH / MAP_MEM_WIDTH / 1  map write port.
REQ-015 query_addr  in  ADDR_WIDTH  tile probed by renderer or player logic.
REQ-016 blast_hit  out  1  query_addr lies in the active blast (registered, 1-cycle latency).
REQ-017 blast_active  out  1  a blast is currently displayed.
REQ-018 busy  out  1  block is not idle.

Function
REQ-019 FSM states SHALL be IDLE, DECODE, RD, CHK, HOLD.
REQ-020 IDLE: trigger_explosion SHALL latch bomb_addr into rem, clear row to 0, and go to DECODE; a trigger in any other state SHALL be ignored.
REQ-021 DECODE: if rem >= NUM_COL, subtract NUM_COL from rem and increment row, one subtraction per cycle; otherwise set col = rem, record the centre tile in entry 0, and go to RD with dir = UP and step k = 1.
REQ-022 Blast list SHALL hold 1+4*BLAST_RANGE address entries, each with a valid bit.
REQ-023 Directions SHALL be processed in the order UP, DOWN, LEFT, RIGHT.
REQ-024 RD: if the target tile is off-map (row-k<0, row+k>NUM_ROW-1, col-k<0, or col+k>NUM_COL-1) or k > BLAST_RANGE, advance to the next direction with k = 1 and issue no read; otherwise drive rd_addr with the target tile and go to CHK.
REQ-025 Column moves SHALL never wrap into the adjacent row.
REQ-026 CHK, code 0: record the tile, k++, return to RD.
REQ-027 CHK, code 1: record nothing and end the direction.
REQ-028 CHK, code 2: record the tile, pulse wr_en one cycle with wr_data 0 at that address, and end the direction.
REQ-029 CHK, code 3: record the tile and end the direction; chain detonation is out of scope.
REQ-030 After RIGHT ends, go to HOLD with the tick counter at 0.
REQ-031 HOLD: count tick pulses; on the BLAST_TICKS-th tick, clear all valid bits and go to IDLE.
REQ-032 blast_active SHALL be high from the cycle after entry 0 is recorded until the valid bits are cleared.
REQ-033 busy SHALL be high whenever state is not IDLE.
REQ-034 blast_hit SHALL be high one cycle after query_addr matches any valid entry.
REQ-035 wr_en SHALL be asserted only in CHK with code 2.
REQ-036 wr_data SHALL always be 0; rd_addr SHALL hold its last value outside RD.

Reset
REQ-037 rst SHALL force IDLE, clear all valid bits and counters, and drive blast_hit, blast_active, busy, and wr_en to 0 on the next edge; a reset mid-scan SHALL abort with no further writes.

Verification
REQ-038 Open map (all 0), bomb_addr=20, range 2 -> entries {20, 1, 39, 58, 19, 21, 22}; UP stops at row 0, LEFT stops at col 0; no wr_en.
REQ-039 Tile 21 = 1 (wall), bomb_addr=20 -> 21 and 22 not recorded; blast_hit=0 for query 22.
REQ-040 Tile 39 = 2, bomb_addr=20 -> exactly one wr_en pulse with addr 39, data 0; 39 recorded; 58 not recorded.
REQ-041 After HOLD is entered, 29 ticks -> blast_active stays 1; 30th tick -> blast_active=0, busy=0 next cycle.
REQ-042 Second trigger during DECODE or HOLD -> ignored; blast list unchanged.
REQ-043 rst asserted in CHK before a code-2 write -> no wr_en; all outputs 0; a subsequent trigger works normally.

Source files
------------

// File: rtl/blast_propagator.sv
`default_nettype none
// ============================================================================
// Module   : blast_propagator
// Purpose  : Scans outward from a detonated bomb tile in four directions,
//            records reached tiles in a small blast list, clears breakable
//            tiles in the map, and holds the blast for a number of frames.
// Revision : 1.0 - initial release
// ============================================================================
module blast_propagator #(
    parameter int NUM_ROW       = 11,
    parameter int NUM_COL       = 19,
    parameter int MAP_MEM_WIDTH = 2,
    parameter int BLAST_RANGE   = 2,
    parameter int BLAST_TICKS   = 30,
    parameter int ADDR_WIDTH    = $clog2(NUM_ROW * NUM_COL)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tick_i,
    input  logic                     trigger_explosion_i,
    input  logic [ADDR_WIDTH-1:0]    bomb_addr_i,
    output logic [ADDR_WIDTH-1:0]    rd_addr_o,
    input  logic [MAP_MEM_WIDTH-1:0] rd_data_i,
    output logic [ADDR_WIDTH-1:0]    wr_addr_o,
    output logic [MAP_MEM_WIDTH-1:0] wr_data_o,
    output logic                     wr_en_o,
    input  logic [ADDR_WIDTH-1:0]    query_addr_i,
    output logic                     blast_hit_o,
    output logic                     blast_active_o,
    output logic                     busy_o
);

    localparam int NENT = 1 + 4 * BLAST_RANGE;
    localparam int PW   = $clog2(NENT + 1);
    localparam int TW   = $clog2(BLAST_TICKS + 1);

    localparam logic [2:0] c_S_IDLE   = 3'd0;
    localparam logic [2:0] c_S_DECODE = 3'd1;
    localparam logic [2:0] c_S_RD     = 3'd2;
    localparam logic [2:0] c_S_CHK    = 3'd3;
    localparam logic [2:0] c_S_HOLD   = 3'd4;

    localparam logic [1:0] c_DIR_UP    = 2'd0;
    localparam logic [1:0] c_DIR_DOWN  = 2'd1;
    localparam logic [1:0] c_DIR_LEFT  = 2'd2;
    localparam logic [1:0] c_DIR_RIGHT = 2'd3;

    localparam logic [MAP_MEM_WIDTH-1:0] c_CODE_EMPTY = MAP_MEM_WIDTH'(0);
    localparam logic [MAP_MEM_WIDTH-1:0] c_CODE_WALL  = MAP_MEM_WIDTH'(1);
    localparam logic [MAP_MEM_WIDTH-1:0] c_CODE_BRK   = MAP_MEM_WIDTH'(2);

    localparam logic [ADDR_WIDTH-1:0] c_NUM_COL   = ADDR_WIDTH'(NUM_COL);
    localparam logic [ADDR_WIDTH-1:0] c_ROW_MAX   = ADDR_WIDTH'(NUM_ROW - 1);
    localparam logic [ADDR_WIDTH-1:0] c_COL_MAX   = ADDR_WIDTH'(NUM_COL - 1);
    localparam logic [ADDR_WIDTH-1:0] c_RANGE     = ADDR_WIDTH'(BLAST_RANGE);
    localparam logic [TW-1:0]         c_TICK_LAST = TW'(BLAST_TICKS - 1);

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] rem_q, row_q, col_q, k_q, rd_addr_q;
    logic [1:0]            dir_q;
    logic [TW-1:0]         tick_cnt_q;
    logic [PW-1:0]         idx_q;
    logic [NENT-1:0]       valid_q;
    logic [ADDR_WIDTH-1:0] entries_q [NENT];
    logic                  blast_hit_q;

    logic [ADDR_WIDTH-1:0] w_tgt_row, w_tgt_col, w_tgt_addr, w_rec_addr;
    logic                  w_off, w_rec, w_end_dir, w_hit, w_hold_done;

    // Target tile of the current direction/step and whether it is unreachable
    always_comb begin
        w_tgt_row = row_q;
        w_tgt_col = col_q;
        w_off     = 1'b0;
        case (dir_q)
            c_DIR_UP: begin
                w_off     = (k_q > row_q);
                w_tgt_row = row_q - k_q;
            end
            c_DIR_DOWN: begin
                w_off     = ((row_q + k_q) > c_ROW_MAX);
                w_tgt_row = row_q + k_q;
            end
            c_DIR_LEFT: begin
                w_off     = (k_q > col_q);
                w_tgt_col = col_q - k_q;
            end
            default: begin
                w_off     = ((col_q + k_q) > c_COL_MAX);
                w_tgt_col = col_q + k_q;
            end
        endcase
        if (k_q > c_RANGE) begin
            w_off = 1'b1;
        end
        w_tgt_addr = w_tgt_row * c_NUM_COL + w_tgt_col;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_S_IDLE:   if (trigger_explosion_i) state_d = c_S_DECODE;
            c_S_DECODE: if (rem_q < c_NUM_COL) state_d = c_S_RD;
            c_S_RD: begin
                if (!w_off) begin
                    state_d = c_S_CHK;
                end else if (dir_q == c_DIR_RIGHT) begin
                    state_d = c_S_HOLD;
                end
            end
            c_S_CHK: begin
                if (w_end_dir && (dir_q == c_DIR_RIGHT)) begin
                    state_d = c_S_HOLD;
                end else begin
                    state_d = c_S_RD;
                end
            end
            c_S_HOLD:   if (w_hold_done) state_d = c_S_IDLE;
            default:    state_d = c_S_IDLE;
        endcase
    end

    // Output and control decode from the current state
    always_comb begin
        busy_o         = (state_q != c_S_IDLE);
        blast_active_o = valid_q[0];
        blast_hit_o    = blast_hit_q;
        wr_addr_o      = rd_addr_q;
        wr_data_o      = c_CODE_EMPTY;
        // Gate with rst so a reset landing in CHK never lets a clear escape.
        wr_en_o        = (state_q == c_S_CHK) && (rd_data_i == c_CODE_BRK) && !rst;
        rd_addr_o      = ((state_q == c_S_RD) && !w_off) ? w_tgt_addr : rd_addr_q;
        w_end_dir      = (rd_data_i != c_CODE_EMPTY);
        w_hold_done    = tick_i && (tick_cnt_q == c_TICK_LAST);
        w_rec          = 1'b0;
        w_rec_addr     = rd_addr_q;
        if ((state_q == c_S_DECODE) && (rem_q < c_NUM_COL)) begin
            w_rec      = 1'b1;
            w_rec_addr = row_q * c_NUM_COL + rem_q;
        end else if ((state_q == c_S_CHK) && (rd_data_i != c_CODE_WALL)) begin
            w_rec      = 1'b1;
        end
    end

    // Query match against every valid blast list entry
    always_comb begin
        w_hit = 1'b0;
        for (int i = 0; i < NENT; i++) begin
            if (valid_q[i] && (entries_q[i] == query_addr_i)) begin
                w_hit = 1'b1;
            end
        end
    end

    // Datapath: address decode, scan cursor, blast list and frame counter
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q       <= '0;
            row_q       <= '0;
            col_q       <= '0;
            k_q         <= '0;
            dir_q       <= c_DIR_UP;
            rd_addr_q   <= '0;
            tick_cnt_q  <= '0;
            idx_q       <= '0;
            valid_q     <= '0;
            blast_hit_q <= 1'b0;
        end else begin
            rd_addr_q   <= rd_addr_o;
            blast_hit_q <= w_hit;
            if (w_rec) begin
                for (int i = 0; i < NENT; i++) begin
                    if (idx_q == PW'(i)) begin
                        entries_q[i] <= w_rec_addr;
                        valid_q[i]   <= 1'b1;
                    end
                end
                idx_q <= idx_q + PW'(1);
            end
            case (state_q)
                c_S_IDLE: begin
                    if (trigger_explosion_i) begin
                        rem_q <= bomb_addr_i;
                        row_q <= '0;
                        idx_q <= '0;
                    end
                end
                c_S_DECODE: begin
                    if (rem_q >= c_NUM_COL) begin
                        rem_q <= rem_q - c_NUM_COL;
                        row_q <= row_q + ADDR_WIDTH'(1);
                    end else begin
                        col_q <= rem_q;
                        dir_q <= c_DIR_UP;
                        k_q   <= ADDR_WIDTH'(1);
                    end
                end
                c_S_RD: begin
                    tick_cnt_q <= '0;
                    if (w_off) begin
                        dir_q <= dir_q + 2'd1;
                        k_q   <= ADDR_WIDTH'(1);
                    end
                end
                c_S_CHK: begin
                    tick_cnt_q <= '0;
                    if (w_end_dir) begin
                        dir_q <= dir_q + 2'd1;
                        k_q   <= ADDR_WIDTH'(1);
                    end else begin
                        k_q   <= k_q + ADDR_WIDTH'(1);
                    end
                end
                c_S_HOLD: begin
                    if (tick_i) begin
                        if (w_hold_done) begin
                            tick_cnt_q <= '0;
                            valid_q    <= '0;
                        end else begin
                            tick_cnt_q <= tick_cnt_q + TW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_blast_propagator.sv
`default_nettype none
// ============================================================================
// Module   : tb_blast_propagator
// Purpose  : Directed and randomized checks of blast_propagator against a
//            tile-walking reference model and a behavioural map memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_blast_propagator;

    localparam int NR = 11;
    localparam int NC = 19;
    localparam int MW = 2;
    localparam int BR = 2;
    localparam int BT = 30;
    localparam int AW = $clog2(NR * NC);
    localparam int NT = NR * NC;

    logic          clk = 1'b0;
    logic          rst, tick, trig, ld;
    logic [AW-1:0] bomb, rd_addr, wr_addr, query;
    logic [MW-1:0] rd_data, wr_data;
    logic          wr_en, hit, active, busy;

    logic [MW-1:0] mem [NT];
    logic [MW-1:0] img [NT];

    int n_vec = 0;
    int n_err = 0;
    int wr_a[$];
    int wr_d[$];

    bit exp_hit [NT];
    int exp_wa[$];

    always #5 clk = ~clk;

    blast_propagator #(
        .NUM_ROW(NR), .NUM_COL(NC), .MAP_MEM_WIDTH(MW),
        .BLAST_RANGE(BR), .BLAST_TICKS(BT)
    ) dut (
        .clk(clk), .rst(rst), .tick_i(tick), .trigger_explosion_i(trig),
        .bomb_addr_i(bomb), .rd_addr_o(rd_addr), .rd_data_i(rd_data),
        .wr_addr_o(wr_addr), .wr_data_o(wr_data), .wr_en_o(wr_en),
        .query_addr_i(query), .blast_hit_o(hit), .blast_active_o(active),
        .busy_o(busy)
    );

    // Map memory: bulk load from the image, DUT writes, registered read
    always @(posedge clk) begin
        if (ld) begin
            mem <= img;
        end else if (wr_en === 1'b1) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

    // Log every write the DUT issues
    always @(posedge clk) begin
        if (wr_en === 1'b1) begin
            wr_a.push_back(int'(wr_addr));
            wr_d.push_back(int'(wr_data));
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: walk outward tile by tile over the map image
    function automatic void model(input int b);
        int r0, c0, r, c, t;
        int dr[4];
        int dc[4];
        dr = '{-1, 1, 0, 0};
        dc = '{0, 0, -1, 1};
        r0 = b / NC;
        c0 = b % NC;
        foreach (exp_hit[i]) exp_hit[i] = 1'b0;
        exp_wa.delete();
        exp_hit[b] = 1'b1;
        for (int d = 0; d < 4; d++) begin
            for (int k = 1; k <= BR; k++) begin
                r = r0 + dr[d] * k;
                c = c0 + dc[d] * k;
                if (r < 0 || r >= NR || c < 0 || c >= NC) break;
                t = r * NC + c;
                if (img[t] == 2'd1) break;
                exp_hit[t] = 1'b1;
                if (img[t] == 2'd2) begin
                    exp_wa.push_back(t);
                    break;
                end
                if (img[t] == 2'd3) break;
            end
        end
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_map();
        @(negedge clk) ld = 1'b1;
        @(negedge clk) ld = 1'b0;
    endtask

    task automatic fire(input int b);
        @(negedge clk);
        trig = 1'b1;
        bomb = AW'(b);
        @(negedge clk);
        trig = 1'b0;
    endtask

    task automatic clear_img();
        foreach (img[i]) img[i] = 2'd0;
    endtask

    // Verify writes, full blast footprint, and the hold timing of one blast
    task automatic finish_blast(input int b, input int s);
        int nw;
        check("hold_busy", busy, 1);
        check("hold_active", active, 1);
        nw = wr_a.size() - s;
        check("wr_count", nw, exp_wa.size());
        for (int i = 0; i < nw && i < exp_wa.size(); i++) begin
            check("wr_addr", wr_a[s + i], exp_wa[i]);
            check("wr_data", wr_d[s + i], 0);
        end
        for (int t = 0; t < NT; t++) begin
            query = AW'(t);
            @(negedge clk);
            check($sformatf("hit_%0d", t), hit, exp_hit[t]);
        end
        for (int i = 1; i <= BT; i++) begin
            idle($urandom_range(0, 2));
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
            if (i < BT) begin
                check($sformatf("active_tick%0d", i), active, 1);
            end else begin
                check("active_end", active, 0);
                check("busy_end", busy, 0);
            end
        end
        query = AW'(b);
        @(negedge clk);
        check("hit_after_end", hit, 0);
    endtask

    task automatic run_blast(input int b);
        int s;
        model(b);
        s = wr_a.size();
        fire(b);
        idle(80);
        finish_blast(b, s);
    endtask

    initial begin
        int s, n, b1;
        rst = 1'b1; tick = 1'b0; trig = 1'b0; ld = 1'b0;
        query = '0; bomb = '0;
        clear_img();
        idle(3);
        check("rst_busy", busy, 0);
        check("rst_active", active, 0);
        check("rst_hit", hit, 0);
        check("rst_wr_en", wr_en, 0);
        rst = 1'b0;

        // Open map around bomb 20
        load_map();
        run_blast(20);

        // Wall to the right of the bomb
        img[21] = 2'd1;
        load_map();
        run_blast(20);
        clear_img();

        // Breakable tile below the bomb
        img[39] = 2'd2;
        load_map();
        run_blast(20);
        clear_img();

        // Random maps and bomb positions, including edges and corners
        for (int it = 0; it < 8; it++) begin
            foreach (img[i]) begin
                n = $urandom_range(0, 9);
                img[i] = (n < 6) ? 2'd0 : MW'(n - 5);
            end
            load_map();
            case (it)
                0: run_blast(0);
                1: run_blast(NT - 1);
                2: run_blast(NC - 1);
                default: run_blast($urandom_range(0, NT - 1));
            endcase
        end

        // Extra triggers during DECODE and HOLD must be ignored
        foreach (img[i]) img[i] = MW'($urandom_range(0, 3));
        load_map();
        b1 = $urandom_range(100, NT - 1);
        model(b1);
        s = wr_a.size();
        fire(b1);
        idle(1);
        fire($urandom_range(0, 99));
        idle(80);
        fire($urandom_range(0, NT - 1));
        idle(5);
        finish_blast(b1, s);

        // Reset while sitting in CHK on a breakable tile
        clear_img();
        img[39] = 2'd2;
        load_map();
        query = AW'(20);
        s = wr_a.size();
        fire(20);
        n = 0;
        while (!(rd_addr === AW'(39) && busy === 1'b1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("reach_rd39", n < 100, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("chk_rst_wr_en", wr_en, 0);
        @(negedge clk);
        check("post_rst_busy", busy, 0);
        check("post_rst_active", active, 0);
        check("post_rst_hit", hit, 0);
        check("post_rst_wr_en", wr_en, 0);
        check("post_rst_writes", wr_a.size() - s, 0);
        rst = 1'b0;
        idle(2);
        check("post_rst_mem39", mem[39], 2);
        run_blast(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
